// File: rtl/gcm_tag_final.sv
// GCM finalisation: counts AAD/text bytes, offers len(A)||len(C) to GHASH,
// then forms tag = S ^ E(K,Y0) and, when decrypting, checks it against the received tag.
module gcm_tag_final #(
    parameter int CNT_W     = 36,
    parameter int TAG_BYTES = 16
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iStart,
    input  logic         iEncdec,
    input  logic         iAad_valid,
    input  logic [3:0]   iAad_bytes,
    input  logic         iText_valid,
    input  logic [3:0]   iText_bytes,
    input  logic         iFinal,
    output logic [127:0] oLen_block,
    output logic         oLen_valid,
    input  logic         iLen_ready,
    input  logic [127:0] iS,
    input  logic         iS_valid,
    input  logic [127:0] iEky0,
    input  logic         iEky0_valid,
    input  logic [127:0] iTag,
    input  logic         iTag_valid,
    output logic [127:0] oTag,
    output logic         oTag_valid,
    output logic         oAuthentic,
    output logic         oBusy,
    output logic         oError
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_LEN_OUT,
        S_WAIT_S,
        S_WAIT_EK,
        S_FINAL
    } state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0] aad_cnt_reg, aad_cnt_next;
    logic [CNT_W-1:0] txt_cnt_reg, txt_cnt_next;
    logic             err_reg, err_next;
    logic             len_valid_reg, len_valid_next;
    logic             ek_held_reg, ek_held_next;
    logic             enc_reg, enc_next;
    logic             auth_reg, auth_next;
    logic [127:0]     s_reg, s_next;
    logic [127:0]     ek_reg, ek_next;
    logic [127:0]     rx_tag_reg, rx_tag_next;
    logic [127:0]     tag_reg, tag_next;

    // A zero byte count encodes a full 16-byte block.
    logic [4:0]       aad_add, txt_add;
    logic [CNT_W:0]   aad_sum, txt_sum;

    assign aad_add = (iAad_bytes == 4'd0) ? 5'd16 : {1'b0, iAad_bytes};
    assign txt_add = (iText_bytes == 4'd0) ? 5'd16 : {1'b0, iText_bytes};
    assign aad_sum = {1'b0, aad_cnt_reg} + {{(CNT_W-4){1'b0}}, aad_add};
    assign txt_sum = {1'b0, txt_cnt_reg} + {{(CNT_W-4){1'b0}}, txt_add};

    // Candidate tag built from the values that will be held once FINAL is entered.
    logic [127:0] s_cand, ek_cand, tag_cand, rx_cand;
    logic [TAG_BYTES-1:0] byte_eq;
    logic                 tag_match;

    assign s_cand   = (state_reg == S_WAIT_S && iS_valid) ? iS : s_reg;
    assign ek_cand  = (state_reg != S_IDLE && iEky0_valid) ? iEky0 : ek_reg;
    assign tag_cand = s_cand ^ ek_cand;
    assign rx_cand  = iTag_valid ? iTag : rx_tag_reg;

    genvar gi;
    generate
        for (gi = 0; gi < TAG_BYTES; gi++) begin : g_byte_cmp
            assign byte_eq[gi] = (tag_cand[127-8*gi -: 8] == rx_cand[127-8*gi -: 8]);
        end
    endgenerate
    assign tag_match = &byte_eq;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        aad_cnt_next   = aad_cnt_reg;
        txt_cnt_next   = txt_cnt_reg;
        err_next       = err_reg;
        len_valid_next = len_valid_reg;
        ek_held_next   = ek_held_reg;
        enc_next       = enc_reg;
        auth_next      = auth_reg;
        s_next         = s_reg;
        ek_next        = ek_reg;
        rx_tag_next    = rx_cand;
        tag_next       = tag_reg;

        if (iStart) begin
            state_next     = S_ACCUM;
            aad_cnt_next   = '0;
            txt_cnt_next   = '0;
            err_next       = 1'b0;
            len_valid_next = 1'b0;
            ek_held_next   = 1'b0;
            enc_next       = iEncdec;
            auth_next      = 1'b0;
        end else begin
            if (state_reg != S_IDLE && iEky0_valid) begin
                ek_next      = iEky0;
                ek_held_next = 1'b1;
            end
            case (state_reg)
                S_ACCUM: begin
                    if (iAad_valid) begin
                        if (txt_cnt_reg != '0) begin
                            err_next = 1'b1;
                        end
                        if (aad_sum[CNT_W]) begin
                            err_next     = 1'b1;
                            aad_cnt_next = '1;
                        end else begin
                            aad_cnt_next = aad_sum[CNT_W-1:0];
                        end
                    end
                    if (iText_valid) begin
                        if (txt_sum[CNT_W]) begin
                            err_next     = 1'b1;
                            txt_cnt_next = '1;
                        end else begin
                            txt_cnt_next = txt_sum[CNT_W-1:0];
                        end
                    end
                    if (iFinal) begin
                        state_next     = S_LEN_OUT;
                        len_valid_next = 1'b1;
                    end
                end
                S_LEN_OUT: begin
                    if (iLen_ready) begin
                        state_next     = S_WAIT_S;
                        len_valid_next = 1'b0;
                    end
                end
                S_WAIT_S: begin
                    if (iS_valid) begin
                        s_next     = iS;
                        state_next = ek_held_next ? S_FINAL : S_WAIT_EK;
                    end
                end
                S_WAIT_EK: begin
                    if (iEky0_valid) begin
                        state_next = S_FINAL;
                    end
                end
                S_FINAL: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
            if (state_next == S_FINAL) begin
                tag_next  = tag_cand;
                auth_next = !enc_reg && tag_match && !err_reg;
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            aad_cnt_reg   <= '0;
            txt_cnt_reg   <= '0;
            err_reg       <= 1'b0;
            len_valid_reg <= 1'b0;
            ek_held_reg   <= 1'b0;
            enc_reg       <= 1'b0;
            auth_reg      <= 1'b0;
            s_reg         <= '0;
            ek_reg        <= '0;
            rx_tag_reg    <= '0;
            tag_reg       <= '0;
        end else begin
            aad_cnt_reg   <= aad_cnt_next;
            txt_cnt_reg   <= txt_cnt_next;
            err_reg       <= err_next;
            len_valid_reg <= len_valid_next;
            ek_held_reg   <= ek_held_next;
            enc_reg       <= enc_next;
            auth_reg      <= auth_next;
            s_reg         <= s_next;
            ek_reg        <= ek_next;
            rx_tag_reg    <= rx_tag_next;
            tag_reg       <= tag_next;
        end
    end

    // Lengths are reported in bits: byte count shifted left by three.
    assign oLen_block = {{(61-CNT_W){1'b0}}, aad_cnt_reg, 3'b000,
                         {(61-CNT_W){1'b0}}, txt_cnt_reg, 3'b000};
    assign oLen_valid = len_valid_reg;
    assign oTag       = tag_reg;
    assign oTag_valid = (state_reg == S_FINAL);
    assign oAuthentic = auth_reg;
    assign oBusy      = (state_reg != S_IDLE);
    assign oError     = err_reg;

endmodule

// File: tb/tb_gcm_tag_final.sv
// Directed bench for gcm_tag_final; a CNT_W=5 copy shares the stimulus for the saturation case.
module tb_gcm_tag_final;

    logic         iClk = 1'b0;
    logic         iRst;
    logic         iStart, iEncdec, iAad_valid, iText_valid, iFinal, iLen_ready;
    logic [3:0]   iAad_bytes, iText_bytes;
    logic [127:0] iS, iEky0, iTag;
    logic         iS_valid, iEky0_valid, iTag_valid;

    logic [127:0] oLen_block, oTag, oLen_block_5, oTag_5;
    logic         oLen_valid, oTag_valid, oAuthentic, oBusy, oError;
    logic         oLen_valid_5, oTag_valid_5, oAuthentic_5, oBusy_5, oError_5;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [127:0] NIST_EK = 128'h58e2fccefa7e3061367f1d57a4e7455a;

    always #5 iClk = ~iClk;

    gcm_tag_final dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iEncdec(iEncdec),
        .iAad_valid(iAad_valid), .iAad_bytes(iAad_bytes),
        .iText_valid(iText_valid), .iText_bytes(iText_bytes), .iFinal(iFinal),
        .oLen_block(oLen_block), .oLen_valid(oLen_valid), .iLen_ready(iLen_ready),
        .iS(iS), .iS_valid(iS_valid), .iEky0(iEky0), .iEky0_valid(iEky0_valid),
        .iTag(iTag), .iTag_valid(iTag_valid), .oTag(oTag), .oTag_valid(oTag_valid),
        .oAuthentic(oAuthentic), .oBusy(oBusy), .oError(oError)
    );

    gcm_tag_final #(.CNT_W(5)) dut5 (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iEncdec(iEncdec),
        .iAad_valid(iAad_valid), .iAad_bytes(iAad_bytes),
        .iText_valid(iText_valid), .iText_bytes(iText_bytes), .iFinal(iFinal),
        .oLen_block(oLen_block_5), .oLen_valid(oLen_valid_5), .iLen_ready(iLen_ready),
        .iS(iS), .iS_valid(iS_valid), .iEky0(iEky0), .iEky0_valid(iEky0_valid),
        .iTag(iTag), .iTag_valid(iTag_valid), .oTag(oTag_5), .oTag_valid(oTag_valid_5),
        .oAuthentic(oAuthentic_5), .oBusy(oBusy_5), .oError(oError_5)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic do_start(input logic enc);
        iStart  = 1'b1;
        iEncdec = enc;
        tick();
        iStart  = 1'b0;
    endtask

    task automatic load_tag(input logic [127:0] t);
        iTag       = t;
        iTag_valid = 1'b1;
        tick();
        iTag_valid = 1'b0;
    endtask

    // Called one cycle after iFinal: length block must already be offered.
    task automatic len_handshake(input string tag, input logic [127:0] exp_len);
        check_eq({tag, "_len_valid"}, oLen_valid, 1'b1);
        check_eq({tag, "_len_block"}, oLen_block, exp_len);
        iLen_ready = 1'b1;
        tick();
        iLen_ready = 1'b0;
        check_eq({tag, "_len_drop"}, oLen_valid, 1'b0);
    endtask

    // S first, then E(K,Y0): FINAL follows the Ek cycle.
    task automatic finish_tag(input string tag, input logic [127:0] s, input logic [127:0] ek,
                              input logic [127:0] exp_tag, input logic exp_auth);
        iS = s;
        iS_valid = 1'b1;
        tick();
        iS_valid = 1'b0;
        check_eq({tag, "_no_early_tag"}, oTag_valid, 1'b0);
        iEky0 = ek;
        iEky0_valid = 1'b1;
        tick();
        iEky0_valid = 1'b0;
        check_eq({tag, "_tag_valid"}, oTag_valid, 1'b1);
        check_eq({tag, "_tag"}, oTag, exp_tag);
        check_eq({tag, "_auth"}, oAuthentic, exp_auth);
        tick();
        check_eq({tag, "_tag_pulse"}, oTag_valid, 1'b0);
        check_eq({tag, "_tag_hold"}, oTag, exp_tag);
        check_eq({tag, "_auth_hold"}, oAuthentic, exp_auth);
        check_eq({tag, "_idle"}, oBusy, 1'b0);
        $display("[TB] %s: tag=%h auth=%0b err=%0b", tag, oTag, oAuthentic, oError);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iRst = 1'b1;
        iStart = 0; iEncdec = 0; iAad_valid = 0; iText_valid = 0; iFinal = 0; iLen_ready = 0;
        iAad_bytes = 0; iText_bytes = 0; iS = 0; iEky0 = 0; iTag = 0;
        iS_valid = 0; iEky0_valid = 0; iTag_valid = 0;
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1'b0;
        tick();

        check_eq("rst_busy", oBusy, 1'b0);
        check_eq("rst_len_valid", oLen_valid, 1'b0);
        check_eq("rst_len_block", oLen_block, 128'h0);
        check_eq("rst_tag", oTag, 128'h0);
        check_eq("rst_tag_valid", oTag_valid, 1'b0);
        check_eq("rst_auth", oAuthentic, 1'b0);
        check_eq("rst_err", oError, 1'b0);

        // 1: NIST case 1, encrypt, empty message
        do_start(1'b1);
        check_eq("t1_busy", oBusy, 1'b1);
        iFinal = 1'b1;
        tick();
        iFinal = 1'b0;
        len_handshake("t1", 128'h0);
        finish_tag("t1", 128'h0, NIST_EK, NIST_EK, 1'b0);

        // 2: decrypt, matching then mismatching tag
        load_tag(NIST_EK);
        do_start(1'b0);
        iFinal = 1'b1;
        tick();
        iFinal = 1'b0;
        len_handshake("t2a", 128'h0);
        finish_tag("t2a", 128'h0, NIST_EK, NIST_EK, 1'b1);
        load_tag(NIST_EK ^ 128'h1);
        do_start(1'b0);
        check_eq("t2b_auth_cleared", oAuthentic, 1'b0);
        iFinal = 1'b1;
        tick();
        iFinal = 1'b0;
        len_handshake("t2b", 128'h0);
        finish_tag("t2b", 128'h0, NIST_EK, NIST_EK, 1'b0);

        // 3: AAD 16+4, text 16+16+16+12 (last one with iFinal)
        do_start(1'b1);
        iAad_valid = 1; iAad_bytes = 4'd0;
        tick();
        iAad_bytes = 4'd4; iText_valid = 1; iText_bytes = 4'd0;
        tick();
        iAad_valid = 0;
        tick();
        tick();
        iText_bytes = 4'd12; iFinal = 1;
        tick();
        iText_valid = 0; iFinal = 0;
        check_eq("t3_err", oError, 1'b0);
        len_handshake("t3", 128'h00000000000000a0_00000000000001e0);
        finish_tag("t3", 128'h0123456789abcdef_fedcba9876543210,
                   128'hffffffff00000000_ffffffff00000000,
                   128'hfedcba9889abcdef_0123456776543210, 1'b0);

        // 4: Ek early, length held off for 3 cycles, FINAL straight from WAIT_S
        do_start(1'b1);
        iText_valid = 1; iText_bytes = 4'd0;
        iEky0 = {64{2'b01}}; iEky0_valid = 1;
        tick();
        iText_valid = 0; iEky0_valid = 0; iFinal = 1;
        tick();
        iFinal = 0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t4_len_hold_valid", oLen_valid, 1'b1);
            check_eq("t4_len_hold_block", oLen_block, {64'h0, 64'h80});
            tick();
        end
        len_handshake("t4", {64'h0, 64'h80});
        iS = {64{2'b10}}; iS_valid = 1;
        tick();
        iS_valid = 0;
        check_eq("t4_tag_valid", oTag_valid, 1'b1);
        check_eq("t4_tag", oTag, {128{1'b1}});
        tick();
        check_eq("t4_idle", oBusy, 1'b0);
        $display("[TB] t4: tag=%h", oTag);

        // 5: text then AAD in decrypt -> error, authentication refused despite matching tag
        load_tag(128'h0011223344556677_8899aabbccddeeff);
        do_start(1'b0);
        iText_valid = 1; iText_bytes = 4'd0;
        tick();
        iText_valid = 0; iAad_valid = 1; iAad_bytes = 4'd0;
        tick();
        iAad_valid = 0;
        check_eq("t5_err", oError, 1'b1);
        iFinal = 1;
        tick();
        iFinal = 0;
        len_handshake("t5", {64'h80, 64'h80});
        finish_tag("t5", 128'h0, 128'h0011223344556677_8899aabbccddeeff,
                   128'h0011223344556677_8899aabbccddeeff, 1'b0);
        check_eq("t5_err_sticky", oError, 1'b1);
        do_start(1'b1);
        check_eq("t5_err_cleared", oError, 1'b0);

        // 6: 3x16 text bytes; CNT_W=5 copy saturates at 31 bytes
        do_start(1'b1);
        iText_valid = 1; iText_bytes = 4'd0;
        tick();
        tick();
        iFinal = 1;
        tick();
        iText_valid = 0; iFinal = 0;
        check_eq("t6_err_cnt5", oError_5, 1'b1);
        check_eq("t6_len_cnt5", oLen_block_5, {64'h0, 64'hf8});
        check_eq("t6_len_valid_cnt5", oLen_valid_5, 1'b1);
        check_eq("t6_err", oError, 1'b0);
        len_handshake("t6", {64'h0, 64'h180});
        finish_tag("t6", 128'h1, 128'h3, 128'h2, 1'b0);

        // 7: abort in WAIT_S, then async reset while the length is offered
        do_start(1'b1);
        iText_valid = 1; iText_bytes = 4'd0; iFinal = 1;
        tick();
        iText_valid = 0; iFinal = 0;
        len_handshake("t7", {64'h0, 64'h80});
        iStart = 1; iS = 128'h5; iS_valid = 1;
        tick();
        iStart = 0; iS_valid = 0;
        check_eq("t7_abort_busy", oBusy, 1'b1);
        check_eq("t7_abort_no_tag", oTag_valid, 1'b0);
        check_eq("t7_abort_cnt_clear", oLen_block, 128'h0);
        iEky0 = 128'h9; iEky0_valid = 1;
        tick();
        iEky0_valid = 0;
        check_eq("t7_abort_no_tag2", oTag_valid, 1'b0);
        iFinal = 1;
        tick();
        iFinal = 0;
        check_eq("t7_len_valid", oLen_valid, 1'b1);
        #2;
        iRst = 1'b1;
        #1;
        check_eq("t7_rst_len_valid", oLen_valid, 1'b0);
        check_eq("t7_rst_busy", oBusy, 1'b0);
        check_eq("t7_rst_tag", oTag, 128'h0);
        #1;
        iRst = 1'b0;
        tick();
        check_eq("t7_post_rst_busy", oBusy, 1'b0);
        check_eq("t7_post_rst_tag_valid", oTag_valid, 1'b0);
        $display("[TB] t7: abort and reset sequence complete");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
